clock_divider_prog: RTL and testbench

- Parametrised, runtime-programmable successor to the fixed clock divider.
- Produces a divided square wave (clock_div) and two single-cycle enable strobes (tick, tick_rise) from the system clock.
- Downstream logic should consume tick/tick_rise as clock enables in the main clock domain. clock_div is for external/LED observation.
- The divisor can be changed at runtime without runt or glitch periods, and the divider can be paused.

---
 rtl/clock_divider_prog.sv | 92 +++++++++
 tb/tb_clock_divider_prog.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: divided square wave plus toggle/rise enable strobes.
// The divisor changes only at half-period boundaries (or at once while paused), so no runt periods occur.
module clock_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             clock_div,
  output logic             tick,
  output logic             tick_rise,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_pending
);

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] div_pend, div_pend_nxt;
  logic [WIDTH-1:0] div_cur_nxt;
  logic [WIDTH-1:0] div_clamped;
  logic             clock_div_nxt, tick_nxt, tick_rise_nxt, load_pending_nxt;
  logic             terminal;

  assign div_clamped = (div_value == '0) ? ONE : div_value;
  // >= rather than == so the counter recovers if div_cur ever falls below count.
  assign terminal    = (count >= div_cur);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
    count_nxt        = count;
    div_pend_nxt     = div_pend;
    div_cur_nxt      = div_cur;
    clock_div_nxt    = clock_div;
    load_pending_nxt = load_pending;
    tick_nxt         = 1'b0;
    tick_rise_nxt    = 1'b0;

    if (!enable) begin
      if (div_load) begin
        div_cur_nxt      = div_clamped;
        count_nxt        = ONE;
        load_pending_nxt = 1'b0;
      end
    end else if (terminal) begin
      clock_div_nxt = ~clock_div;
      tick_nxt      = 1'b1;
      tick_rise_nxt = ~clock_div;
      count_nxt     = ONE;
      // A load landing exactly on the boundary wins over any stale pending value.
      if (div_load) begin
        div_cur_nxt      = div_clamped;
        load_pending_nxt = 1'b0;
      end else if (load_pending) begin
        div_cur_nxt      = div_pend;
        load_pending_nxt = 1'b0;
      end
    end else begin
      count_nxt = count + ONE;
      if (div_load) begin
        div_pend_nxt     = div_clamped;
        load_pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (!reset_n) begin
      count        <= ONE;
      div_pend     <= '0;
      div_cur      <= DIV_RESET;
      clock_div    <= 1'b0;
      tick         <= 1'b0;
      tick_rise    <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      count        <= count_nxt;
      div_pend     <= div_pend_nxt;
      div_cur      <= div_cur_nxt;
      clock_div    <= clock_div_nxt;
      tick         <= tick_nxt;
      tick_rise    <= tick_rise_nxt;
      load_pending <= load_pending_nxt;
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: per-cycle scoreboard from a behavioural model plus
// hand-traced directed checks for the key boundaries.
module tb_clock_divider_prog;

  logic        clock = 1'b0;
  logic        reset_n, enable, div_load;
  logic [15:0] div_value;
  logic        clock_div, tick, tick_rise, load_pending;
  logic [15:0] div_cur;

  clock_divider_prog #(.WIDTH(16), .DEFAULT_DIV(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .div_load     (div_load),
    .div_value    (div_value),
    .clock_div    (clock_div),
    .tick         (tick),
    .tick_rise    (tick_rise),
    .div_cur      (div_cur),
    .load_pending (load_pending)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        cd;
    logic        tk;
    logic        rs;
    logic [15:0] cur;
    logic        lp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic        m_cd = 1'b0, m_tk = 1'b0, m_rs = 1'b0, m_lp = 1'b0;
  logic [15:0] m_cnt = 16'd1, m_cur = 16'd2, m_pend = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the model's expectation, then compare after the edge.
  task automatic cyc(input logic rn, input logic en, input logic ld, input logic [15:0] val);
    exp_t        e, got;
    logic [15:0] cl;
    reset_n   = rn;
    enable    = en;
    div_load  = ld;
    div_value = val;
    cl = (val == 16'd0) ? 16'd1 : val;
    if (!rn) begin
      m_cd = 0; m_tk = 0; m_rs = 0; m_cnt = 1; m_cur = 2; m_pend = 0; m_lp = 0;
    end else if (!en) begin
      m_tk = 0; m_rs = 0;
      if (ld) begin m_cur = cl; m_cnt = 1; m_lp = 0; end
    end else if (m_cnt >= m_cur) begin
      m_rs = ~m_cd; m_cd = ~m_cd; m_tk = 1; m_cnt = 1;
      if (ld) begin m_cur = cl; m_lp = 0; end
      else if (m_lp) begin m_cur = m_pend; m_lp = 0; end
    end else begin
      m_cnt = m_cnt + 16'd1; m_tk = 0; m_rs = 0;
      if (ld) begin m_pend = cl; m_lp = 1; end
    end
    e = '{cd: m_cd, tk: m_tk, rs: m_rs, cur: m_cur, lp: m_lp};
    sb.push_back(e);
    @(posedge clock);
    #1;
    got = sb.pop_front();
    check("sb_clock_div", 32'(clock_div), 32'(got.cd));
    check("sb_tick", 32'(tick), 32'(got.tk));
    check("sb_tick_rise", 32'(tick_rise), 32'(got.rs));
    check("sb_div_cur", 32'(div_cur), 32'(got.cur));
    check("sb_load_pending", 32'(load_pending), 32'(got.lp));
  endtask

  initial begin
    int n_tick, n_rise;
    reset_n = 1'b0; enable = 1'b0; div_load = 1'b0; div_value = '0;

    // Reset state
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst_clock_div", 32'(clock_div), 0);
    check("rst_div_cur", 32'(div_cur), 2);
    check("rst_load_pending", 32'(load_pending), 0);

    // Default divisor 2: first toggle at 2nd enabled edge
    cyc(1, 1, 0, 0);
    check("def_e1_clock_div", 32'(clock_div), 0);
    cyc(1, 1, 0, 0);
    check("def_e2_clock_div", 32'(clock_div), 1);
    check("def_e2_tick_rise", 32'(tick_rise), 1);
    n_tick = 0; n_rise = 0;
    repeat (6) begin cyc(1, 1, 0, 0); n_tick += int'(tick); n_rise += int'(tick_rise); end
    check("def_tick_count", n_tick, 3);
    check("def_rise_count", n_rise, 1);

    // Load 5 mid half-period: old half-period completes at 2
    cyc(1, 1, 1, 5);
    check("ld5_pending", 32'(load_pending), 1);
    check("ld5_cur_old", 32'(div_cur), 2);
    cyc(1, 1, 0, 0);
    check("ld5_boundary_tick", 32'(tick), 1);
    check("ld5_cur_new", 32'(div_cur), 5);
    check("ld5_pending_clr", 32'(load_pending), 0);
    n_tick = 0;
    repeat (4) begin cyc(1, 1, 0, 0); n_tick += int'(tick); end
    check("ld5_no_early_tick", n_tick, 0);
    cyc(1, 1, 0, 0);
    check("ld5_tick_at_5", 32'(tick), 1);

    // Load 0 clamps to 1: clock/2, tick every cycle
    cyc(1, 1, 1, 0);
    repeat (4) cyc(1, 1, 0, 0);
    check("ld0_cur", 32'(div_cur), 1);
    n_tick = 0;
    repeat (6) begin cyc(1, 1, 0, 0); n_tick += int'(tick); end
    check("ld0_tick_every_cycle", n_tick, 6);
    check("ld0_clock_div", 32'(clock_div), 1);

    // Load while paused applies at once; then a load on the terminal edge (3 -> 7) beats a stale pend of 4
    cyc(1, 0, 1, 3);
    check("pause_ld3_cur", 32'(div_cur), 3);
    cyc(1, 1, 1, 4);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 7);
    check("term_ld7_cur", 32'(div_cur), 7);
    check("term_ld7_pending", 32'(load_pending), 0);
    check("term_ld7_tick", 32'(tick), 1);
    n_tick = 0;
    repeat (7) begin cyc(1, 1, 0, 0); n_tick += int'(tick); end
    check("div7_one_tick", n_tick, 1);
    check("div7_tick_last", 32'(tick), 1);

    // Two loads in one half-period: last write wins
    cyc(1, 1, 1, 4);
    cyc(1, 1, 1, 9);
    repeat (4) cyc(1, 1, 0, 0);
    check("dbl_cur_before", 32'(div_cur), 7);
    check("dbl_pending", 32'(load_pending), 1);
    cyc(1, 1, 0, 0);
    check("dbl_cur_after", 32'(div_cur), 9);

    // Pause mid-count at divisor 4
    cyc(1, 0, 1, 4);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    n_tick = 0;
    repeat (10) begin cyc(1, 0, 0, 0); n_tick += int'(tick); end
    check("pause_tick_zero", n_tick, 0);
    check("pause_clock_div_held", 32'(clock_div), 0);
    cyc(1, 1, 0, 0);
    check("resume_e1_tick", 32'(tick), 0);
    cyc(1, 1, 0, 0);
    check("resume_e2_tick", 32'(tick), 1);
    check("resume_e2_clock_div", 32'(clock_div), 1);

    // Paused load of 6 restarts count at 1
    cyc(1, 0, 1, 6);
    check("pause_ld6_cur", 32'(div_cur), 6);
    check("pause_ld6_clock_div", 32'(clock_div), 1);
    n_tick = 0;
    repeat (5) begin cyc(1, 1, 0, 0); n_tick += int'(tick); end
    check("ld6_no_early_tick", n_tick, 0);
    cyc(1, 1, 0, 0);
    check("ld6_tick_at_6", 32'(tick), 1);
    repeat (6) cyc(1, 1, 0, 0);
    check("pre_rst_clock_div", 32'(clock_div), 1);

    // Reset mid-period with a load pending, and reset beating enable+load
    cyc(1, 1, 1, 10);
    cyc(1, 1, 0, 0);
    check("pre_rst_pending", 32'(load_pending), 1);
    cyc(0, 1, 1, 5);
    check("rst_mid_clock_div", 32'(clock_div), 0);
    check("rst_mid_div_cur", 32'(div_cur), 2);
    check("rst_mid_pending", 32'(load_pending), 0);
    check("rst_mid_tick", 32'(tick), 0);
    cyc(1, 1, 0, 0);
    check("post_rst_e1_clock_div", 32'(clock_div), 0);
    cyc(1, 1, 0, 0);
    check("post_rst_e2_clock_div", 32'(clock_div), 1);
    check("post_rst_e2_div_cur", 32'(div_cur), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
